// File: rtl/k10_uart_rx.sv
// k10_uart_rx: UART0 receive engine.
// Synchronises the serial line and recovers 8N1/8E1/8O1 frames by mid-bit
// sampling against a clocks-per-bit divisor. Good bytes go into a
// first-word-fall-through FIFO that drains through a valid/ready port.
module k10_uart_rx #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              rx_i,
  input  logic [DIV_W-1:0]                  cfg_div_i,
  input  logic                              cfg_par_en_i,
  input  logic                              cfg_par_odd_i,
  output logic [7:0]                        rdata_o,
  output logic                              rvalid_o,
  input  logic                              rready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level_o,
  output logic                              frame_err_o,
  output logic                              par_err_o,
  output logic                              overrun_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  // Line synchroniser and receiver state
  logic [1:0]       r_sync;
  state_t           r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit;
  logic [7:0]       r_data;
  logic             r_par_en;
  logic             r_par_odd;
  logic             r_par_bad;
  logic             r_frame_err;
  logic             r_par_err;

  // FIFO state
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_overrun;

  logic             w_rx_s;
  logic [DIV_W-1:0] w_div_eff;
  logic             w_tick;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_accept;

  assign w_rx_s    = r_sync[1];
  // Divisors below 4 would leave no room for a mid-bit sample.
  assign w_div_eff = (cfg_div_i < MIN_DIV) ? MIN_DIV : cfg_div_i;
  assign w_tick    = (r_cnt == '0);

  // A good byte is offered to the FIFO in the stop-sample cycle itself.
  assign w_push   = (r_state == S_STOP) && w_tick && w_rx_s && !r_par_bad;
  assign w_pop    = (r_level != '0) && rready_i;
  assign w_full   = (r_level == FULL_LVL);
  assign w_accept = w_push && (!w_full || w_pop);

  assign rvalid_o    = (r_level != '0);
  assign rdata_o     = rvalid_o ? r_mem[r_rd_ptr] : 8'h00;
  assign level_o     = r_level;
  assign frame_err_o = r_frame_err;
  assign par_err_o   = r_par_err;
  assign overrun_o   = r_overrun;

  // Two-flop synchroniser; resets to the idle (high) line level.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], rx_i};
  end

  // Frame FSM: start detection, mid-bit sampling, parity/stop checks, error pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_div       <= MIN_DIV;
      r_bit       <= '0;
      r_data      <= '0;
      r_par_en    <= 1'b0;
      r_par_odd   <= 1'b0;
      r_par_bad   <= 1'b0;
      r_frame_err <= 1'b0;
      r_par_err   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_par_err   <= 1'b0;

      // Sampling states count down to the next sample, then reload a full bit.
      if (r_state == S_START || r_state == S_DATA ||
          r_state == S_PARITY || r_state == S_STOP) begin
        r_cnt <= w_tick ? (r_div - DIV_W'(1)) : (r_cnt - DIV_W'(1));
      end

      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            // Configuration is frozen for the whole frame from here on.
            r_state   <= S_START;
            r_div     <= w_div_eff;
            r_par_en  <= cfg_par_en_i;
            r_par_odd <= cfg_par_odd_i;
            r_par_bad <= 1'b0;
            r_cnt     <= (w_div_eff >> 1) - DIV_W'(1);
          end
        end
        S_START: begin
          if (w_tick) begin
            if (w_rx_s) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
              r_bit   <= '0;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_data <= {w_rx_s, r_data[7:1]};
            r_bit  <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= r_par_en ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_par_bad <= ((^r_data) ^ w_rx_s) != r_par_odd;
            r_state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (!w_rx_s) begin
              // Framing error wins over parity; wait out a possible break.
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT_IDLE;
            end else begin
              r_par_err <= r_par_bad;
              r_state   <= S_IDLE;
            end
          end
        end
        S_WAIT_IDLE: begin
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage write.
  // NOTE: the data array has no reset; validity is tracked by the level
  // counter, so clearing it would only add reset fan-out.
  always_ff @(posedge clk_i) begin
    if (w_accept) r_mem[r_wr_ptr] <= r_data;
  end

  // FIFO pointers, occupancy and overrun pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_push && !w_accept;
      if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_accept, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
